// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file constants and types for the write-port arbiter.
// Address/data widths and enable levels live here only.
package regfile_wr_arbiter_pkg;

  localparam int   REG_AW = 5;
  localparam int   REG_DW = 32;
  localparam logic WE_ON  = 1'b1;
  localparam logic RE_ON  = 1'b1;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;

  // r0 is hardwired to zero, so a write to it is no write at all.
  function automatic logic is_real_addr(input reg_addr_t a);
    return a != '0;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bus bundle between the pipeline/multi-cycle unit (master) and the arbiter (slave).
interface regfile_wr_arbiter_if;
  import regfile_wr_arbiter_pkg::*;

  logic      a_we;
  reg_addr_t a_waddr;
  reg_data_t a_wdata;
  logic      b_valid;
  reg_addr_t b_waddr;
  reg_data_t b_wdata;
  logic      b_ready;
  logic      we;
  reg_addr_t wAddr;
  reg_data_t wData;
  logic      re1;
  reg_addr_t rAddr1;
  logic      re2;
  reg_addr_t rAddr2;
  logic      haz1;
  logic      haz2;
  logic      stall_req;

  modport master (
    output a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata, re1, rAddr1, re2, rAddr2,
    input  b_ready, we, wAddr, wData, haz1, haz2, stall_req
  );

  modport slave (
    input  a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata, re1, rAddr1, re2, rAddr2,
    output b_ready, we, wAddr, wData, haz1, haz2, stall_req
  );

endinterface

// File: rtl/regfile_wr_fifo.sv
// Pending-write buffer for port B: FIFO storage with per-entry valid bits,
// address-match vectors for hazard lookup and an address-keyed squash.
module regfile_wr_fifo
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wr_req_t          push_req,
  input  logic             pop,
  input  logic             squash,
  input  reg_addr_t        squash_addr,
  input  reg_addr_t        q1_addr,
  input  reg_addr_t        q2_addr,
  output logic             full,
  output logic             head_present,
  output logic             head_valid,
  output wr_req_t          head_req,
  output logic [DEPTH-1:0] match1,
  output logic [DEPTH-1:0] match2
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [DEPTH-1:0] valid;
  wr_req_t          mem [DEPTH];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      for (int i = 0; i < DEPTH; i++)
        if (squash && mem[i].addr == squash_addr) valid[i] <= 1'b0;
      if (pop)  valid[rd_ptr] <= 1'b0;
      if (push) valid[wr_ptr] <= 1'b1;
    end
  end

  // NOTE: storage has no reset; valid bits alone decide whether an entry means anything.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match1[i] = valid[i] && (mem[i].addr == q1_addr);
      match2[i] = valid[i] && (mem[i].addr == q2_addr);
    end
  end

  assign full         = (count == (PW+1)'(DEPTH));
  assign head_present = (count != '0);
  assign head_valid   = head_present && valid[rd_ptr];
  assign head_req     = mem[rd_ptr];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Single register-file write port shared by pipeline write-back (A, priority)
// and a buffered multi-cycle unit (B), with WAW squash and starvation stall.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wr_arbiter_if.slave bus
);

  localparam int            SW     = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX_C = SW'(STARVE_MAX);

  logic             full;
  logic             head_present;
  logic             head_valid;
  wr_req_t          head_req;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic             a_valid;
  logic             push;
  logic             pop;
  logic [SW-1:0]    starve_cnt;
  logic [SW-1:0]    starve_nxt;
  logic             stall_q;

  assign a_valid = (bus.a_we == WE_ON) && is_real_addr(bus.a_waddr) && !rst;
  assign push    = bus.b_valid && bus.b_ready && is_real_addr(bus.b_waddr);
  // A squashed head is dropped without a write slot, so it may pop even while A wins.
  assign pop     = head_present && (!head_valid || !a_valid);

  regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_req     ('{addr: bus.b_waddr, data: bus.b_wdata}),
    .pop          (pop),
    .squash       (a_valid),
    .squash_addr  (bus.a_waddr),
    .q1_addr      (bus.rAddr1),
    .q2_addr      (bus.rAddr2),
    .full         (full),
    .head_present (head_present),
    .head_valid   (head_valid),
    .head_req     (head_req),
    .match1       (match1),
    .match2       (match2)
  );

  always_comb begin
    bus.we    = 1'b0;
    bus.wAddr = '0;
    bus.wData = '0;
    if (a_valid) begin
      bus.we    = WE_ON;
      bus.wAddr = bus.a_waddr;
      bus.wData = bus.a_wdata;
    end else if (head_valid) begin
      bus.we    = WE_ON;
      bus.wAddr = head_req.addr;
      bus.wData = head_req.data;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (pop)
      starve_nxt = '0;
    else if (head_valid && a_valid && starve_cnt != SMAX_C)
      starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      stall_q    <= (starve_nxt == SMAX_C);
    end
  end

  assign bus.b_ready   = !full;
  assign bus.stall_req = stall_q;
  assign bus.haz1      = (bus.re1 == RE_ON) && is_real_addr(bus.rAddr1) && (|match1);
  assign bus.haz2      = (bus.re2 == RE_ON) && is_real_addr(bus.rAddr2) && (|match2);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: hand-computed expectations plus a
// small register-file model that records every write landing at a clock edge.
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rf [32];
  int          wr_count  = 0;
  int          r9_writes = 0;
  int          r0_writes = 0;

  always @(posedge clk) begin
    if (!rst && bus.we) begin
      rf[bus.wAddr] <= bus.wData;
      wr_count++;
      if (bus.wAddr == 5'd9) r9_writes++;
      if (bus.wAddr == 5'd0) r0_writes++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  int snap;

  initial begin
    rst         = 1'b1;
    bus.a_we    = 1'b1;
    bus.a_waddr = 5'd4;
    bus.a_wdata = 32'h44;
    bus.b_valid = 1'b0;
    bus.b_waddr = '0;
    bus.b_wdata = '0;
    bus.re1     = 1'b1;
    bus.rAddr1  = 5'd4;
    bus.re2     = 1'b0;
    bus.rAddr2  = '0;

    // Reset state: write port gated off even with a_we high.
    mid();
    check("rst_we", bus.we, 1'b0);
    check("rst_b_ready", bus.b_ready, 1'b1);
    check("rst_haz1", bus.haz1, 1'b0);
    check("rst_stall", bus.stall_req, 1'b0);
    tick();
    rst      = 1'b0;
    bus.a_we = 1'b0;
    bus.re1  = 1'b0;

    // Idle A, B writes r5 = 0x1234; lands next cycle.
    bus.b_valid = 1'b1;
    bus.b_waddr = 5'd5;
    bus.b_wdata = 32'h1234;
    mid();
    check("b_idle_ready", bus.b_ready, 1'b1);
    check("b_idle_we0", bus.we, 1'b0);
    tick();
    bus.b_valid = 1'b0;
    mid();
    check("b_idle_we", bus.we, 1'b1);
    check("b_idle_waddr", bus.wAddr, 5'd5);
    check("b_idle_wdata", bus.wData, 32'h1234);
    tick();
    mid();
    check("b_idle_drained", bus.we, 1'b0);

    // A writes every cycle; buffered r3 starves until A goes quiet.
    tick();
    bus.a_we    = 1'b1;
    bus.a_waddr = 5'd11;
    bus.a_wdata = 32'hB0B;
    bus.b_valid = 1'b1;
    bus.b_waddr = 5'd3;
    bus.b_wdata = 32'h33;
    mid();
    check("starve_push_waddr", bus.wAddr, 5'd11);
    tick();
    bus.b_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      mid();
      check("starve_a_granted", bus.wAddr, 5'd11);
      check("starve_stall_low", bus.stall_req, 1'b0);
      tick();
    end
    bus.a_we = 1'b0;
    mid();
    check("starve_stall_high", bus.stall_req, 1'b1);
    check("starve_b_we", bus.we, 1'b1);
    check("starve_b_waddr", bus.wAddr, 5'd3);
    check("starve_b_wdata", bus.wData, 32'h33);
    tick();
    mid();
    check("starve_stall_clr", bus.stall_req, 1'b0);
    check("starve_we_idle", bus.we, 1'b0);

    // Fill with r7, r8 while A busy; hazards; drain in order, no pass-through when full.
    tick();
    bus.a_we    = 1'b1;
    bus.a_waddr = 5'd12;
    bus.a_wdata = 32'hC;
    bus.b_valid = 1'b1;
    bus.b_waddr = 5'd7;
    bus.b_wdata = 32'h77;
    tick();
    bus.b_waddr = 5'd8;
    bus.b_wdata = 32'h88;
    mid();
    check("fill_ready_one", bus.b_ready, 1'b1);
    tick();
    bus.b_valid = 1'b0;
    bus.re1     = 1'b1;
    bus.rAddr1  = 5'd7;
    bus.re2     = 1'b1;
    bus.rAddr2  = 5'd8;
    mid();
    check("fill_full", bus.b_ready, 1'b0);
    check("haz1_r7", bus.haz1, 1'b1);
    check("haz2_r8", bus.haz2, 1'b1);
    bus.rAddr1 = 5'd0;
    #1;
    check("haz1_r0", bus.haz1, 1'b0);
    bus.a_we    = 1'b0;
    bus.b_valid = 1'b1;
    bus.b_waddr = 5'd20;
    bus.b_wdata = 32'h2020;
    bus.re1     = 1'b0;
    bus.re2     = 1'b0;
    #1;
    check("full_pop_ready", bus.b_ready, 1'b0);
    check("drain_r7", bus.wAddr, 5'd7);
    check("drain_r7_data", bus.wData, 32'h77);
    tick();
    bus.b_valid = 1'b0;
    mid();
    check("drain_r8", bus.wAddr, 5'd8);
    check("drain_r8_we", bus.we, 1'b1);
    tick();
    mid();
    check("no_passthru", bus.we, 1'b0);

    // r9 buffered, then A writes r9: entry squashed, single write of 0xAAAA.
    snap        = r9_writes;
    bus.a_we    = 1'b1;
    bus.a_waddr = 5'd13;
    bus.a_wdata = 32'hD;
    bus.b_valid = 1'b1;
    bus.b_waddr = 5'd9;
    bus.b_wdata = 32'h9999;
    tick();
    bus.b_valid = 1'b0;
    bus.re1     = 1'b1;
    bus.rAddr1  = 5'd9;
    mid();
    check("squash_haz_before", bus.haz1, 1'b1);
    bus.a_waddr = 5'd9;
    bus.a_wdata = 32'hAAAA;
    #1;
    check("squash_a_waddr", bus.wAddr, 5'd9);
    check("squash_a_wdata", bus.wData, 32'hAAAA);
    tick();
    bus.a_we = 1'b0;
    mid();
    check("squash_haz_after", bus.haz1, 1'b0);
    check("squash_pop_no_we", bus.we, 1'b0);
    tick();
    mid();
    check("squash_idle", bus.we, 1'b0);
    check("squash_r9_value", rf[9], 32'hAAAA);
    check("squash_r9_writes", r9_writes - snap, 1);
    bus.re1 = 1'b0;

    // B writes r0 while A busy: handshake completes, nothing stored.
    bus.a_we    = 1'b1;
    bus.a_waddr = 5'd14;
    bus.a_wdata = 32'hE;
    bus.b_valid = 1'b1;
    bus.b_waddr = 5'd0;
    bus.b_wdata = 32'hDEAD;
    mid();
    check("r0_ready", bus.b_ready, 1'b1);
    tick();
    bus.b_waddr = 5'd21;
    bus.b_wdata = 32'h21;
    mid();
    check("r0_count_unchanged", bus.b_ready, 1'b1);
    tick();
    bus.b_waddr = 5'd22;
    bus.b_wdata = 32'h22;
    mid();
    check("r0_one_entry", bus.b_ready, 1'b1);
    tick();
    bus.b_valid = 1'b0;
    mid();
    check("r0_two_entries", bus.b_ready, 1'b0);
    check("r0_never_written", r0_writes, 0);

    // Async reset between edges with two entries pending.
    bus.re1    = 1'b1;
    bus.rAddr1 = 5'd21;
    #1;
    check("prerst_haz1", bus.haz1, 1'b1);
    bus.a_we = 1'b0;
    #1;
    check("prerst_head_we", bus.wAddr, 5'd21);
    rst = 1'b1;
    #1;
    check("arst_we", bus.we, 1'b0);
    check("arst_b_ready", bus.b_ready, 1'b1);
    check("arst_haz1", bus.haz1, 1'b0);
    check("arst_stall", bus.stall_req, 1'b0);
    bus.a_we    = 1'b1;
    bus.a_waddr = 5'd15;
    #1;
    check("arst_we_a", bus.we, 1'b0);
    @(posedge clk);
    #2;
    bus.a_we = 1'b0;
    rst      = 1'b0;
    snap     = wr_count;
    tick();
    tick();
    tick();
    mid();
    check("postrst_no_write", wr_count - snap, 0);
    check("postrst_haz1", bus.haz1, 1'b0);
    check("postrst_r0_writes", r0_writes, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
